// File: rtl/axis_snoop_capture.sv
// Passive AXI-Stream tap: decimated field capture into a DEPTH-entry FIFO with beat/drop stats.
// Optional trigger (arm + unsigned threshold) enabled by defining SNOOP_TRIGGER_EN.
module axis_snoop_capture #(
    parameter int C_M00_AXIS_TDATA_WIDTH = 64,
    parameter int FIELD_LSB              = 32,
    parameter int FIELD_WIDTH            = 32,
    parameter int DEPTH                  = 16
) (
    input  logic                              s00_axis_aclk,
    input  logic                              s00_axis_aresetn,
    input  logic                              m00_axis_tready,
    input  logic                              m00_axis_tvalid,
    input  logic [C_M00_AXIS_TDATA_WIDTH-1:0] m00_axis_tdata,
    input  logic                              cfg_enable,
    input  logic [15:0]                       cfg_decim,
    input  logic                              cfg_clear,
    input  logic                              cfg_arm,
    input  logic [FIELD_WIDTH-1:0]            cfg_threshold,
    output logic [FIELD_WIDTH-1:0]            snooped_tdata,
    output logic [FIELD_WIDTH-1:0]            cap_tdata,
    output logic                              cap_tvalid,
    input  logic                              cap_tready,
    output logic [$clog2(DEPTH):0]            cap_level,
    output logic [31:0]                       beat_count,
    output logic [15:0]                       drop_count,
    output logic                              trig_fired
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    typedef enum logic [1:0] {S_IDLE, S_ARMED, S_RUN} state_t;

    state_t                  r_state;
    logic [15:0]             r_dcnt;
    logic [FIELD_WIDTH-1:0]  r_snoop;
    logic [31:0]             r_beat;
    logic [15:0]             r_drop;
    logic [AW-1:0]           r_wr;
    logic [AW-1:0]           r_rd;
    logic [LW-1:0]           r_level;
    logic [FIELD_WIDTH-1:0]  r_mem [DEPTH];

    logic [FIELD_WIDTH-1:0]  w_field;
    logic                    w_hs;
    logic                    w_trig_hit;
    logic                    w_keep;
    logic                    w_full;
    logic                    w_pop;
    logic                    w_push;
    logic                    w_unused_bits;

    assign w_field = m00_axis_tdata[FIELD_LSB +: FIELD_WIDTH];
    assign w_hs    = m00_axis_tvalid & m00_axis_tready;
    // Bits outside the snooped field (and trigger inputs in the plain build) are intentionally ignored.
    assign w_unused_bits = ^{m00_axis_tdata, cfg_arm, cfg_threshold};

`ifdef SNOOP_TRIGGER_EN
    assign w_trig_hit = (r_state == S_ARMED) & w_hs & (w_field >= cfg_threshold);
`else
    assign w_trig_hit = 1'b0;
`endif

    assign w_keep = w_hs & (((r_state == S_RUN) & (r_dcnt == 16'd0)) | w_trig_hit);
    assign w_full = (r_level == LW'(DEPTH));
    assign w_pop  = (r_level != '0) & cap_tready;
    assign w_push = w_keep & (~w_full | w_pop);

    always_ff @(posedge s00_axis_aclk or negedge s00_axis_aresetn) begin
        if (!s00_axis_aresetn) begin
            r_state <= S_IDLE;
            r_dcnt  <= '0;
            r_snoop <= '0;
            r_beat  <= '0;
            r_drop  <= '0;
            r_wr    <= '0;
            r_rd    <= '0;
            r_level <= '0;
        end else if (cfg_clear) begin
            r_state <= S_IDLE;
            r_dcnt  <= '0;
            r_beat  <= '0;
            r_drop  <= '0;
            r_wr    <= '0;
            r_rd    <= '0;
            r_level <= '0;
        end else begin
            if (!cfg_enable) begin
                r_state <= S_IDLE;
            end else begin
                case (r_state)
`ifdef SNOOP_TRIGGER_EN
                    S_IDLE:  if (cfg_arm) r_state <= S_ARMED;
`else
                    S_IDLE:  r_state <= S_RUN;
`endif
                    S_ARMED: if (w_trig_hit) r_state <= S_RUN;
                    S_RUN:   r_state <= S_RUN;
                    default: r_state <= S_IDLE;
                endcase
            end

            if (w_hs && r_state != S_IDLE)
                r_beat <= r_beat + 32'd1;

            // The trigger beat is itself the first kept sample, so it reloads the decimator.
            if (r_state == S_RUN && w_hs)
                r_dcnt <= (r_dcnt == 16'd0) ? cfg_decim : r_dcnt - 16'd1;
            else if (w_trig_hit)
                r_dcnt <= cfg_decim;
            else if (r_state != S_RUN)
                r_dcnt <= '0;

            if (w_keep)
                r_snoop <= w_field;
            if (w_keep && !w_push && r_drop != 16'hFFFF)
                r_drop <= r_drop + 16'd1;

            if (w_push)
                r_wr <= r_wr + AW'(1);
            if (w_pop)
                r_rd <= r_rd + AW'(1);
            if (w_push && !w_pop)
                r_level <= r_level + LW'(1);
            else if (w_pop && !w_push)
                r_level <= r_level - LW'(1);
        end
    end

    always_ff @(posedge s00_axis_aclk) begin
        if (w_push && !cfg_clear)
            r_mem[r_wr] <= w_field;
    end

    assign snooped_tdata = r_snoop;
    assign cap_tdata     = (r_level != '0) ? r_mem[r_rd] : '0;
    assign cap_tvalid    = (r_level != '0);
    assign cap_level     = r_level;
    assign beat_count    = r_beat;
    assign drop_count    = r_drop;
    assign trig_fired    = (r_state == S_RUN);

endmodule

// File: tb/tb_axis_snoop_capture.sv
// Directed, table-driven bench for axis_snoop_capture (default parameters).
module tb_axis_snoop_capture;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        tready = 1'b0, tvalid = 1'b0;
    logic [63:0] tdata = '0;
    logic        en = 1'b0, clr = 1'b0, arm = 1'b0;
    logic [15:0] decim = '0;
    logic [31:0] thr = '0;
    logic [31:0] snoop, cdat;
    logic        cvld, crdy = 1'b0;
    logic [4:0]  lvl;
    logic [31:0] beat;
    logic [15:0] drop;
    logic        trig;

    int n_cmp = 0;
    int n_err = 0;

    axis_snoop_capture dut (
        .s00_axis_aclk(clk), .s00_axis_aresetn(rst_n),
        .m00_axis_tready(tready), .m00_axis_tvalid(tvalid), .m00_axis_tdata(tdata),
        .cfg_enable(en), .cfg_decim(decim), .cfg_clear(clr), .cfg_arm(arm),
        .cfg_threshold(thr), .snooped_tdata(snoop), .cap_tdata(cdat),
        .cap_tvalid(cvld), .cap_tready(crdy), .cap_level(lvl),
        .beat_count(beat), .drop_count(drop), .trig_fired(trig)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        vld;
        logic        rdy;
        logic [31:0] fld;
        logic        crdy;
        logic [4:0]  lvl;
        logic        cvld;
        logic [31:0] cdat;
        logic [31:0] beat;
        logic [31:0] snoop;
    } vec_t;
    vec_t vt [6];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic beat_in(input logic [31:0] fld);
        tvalid = 1'b1; tready = 1'b1;
        tdata  = {fld, 32'h0BAD_0000};
        tick();
    endtask

    task automatic pop_chk(input string nm, input logic [31:0] exp);
        chk({nm, "_vld"}, 64'(cvld), 64'd1);
        chk({nm, "_dat"}, 64'(cdat), 64'(exp));
        crdy = 1'b1;
        tick();
        crdy = 1'b0;
    endtask

    task automatic do_clear();
        clr = 1'b1;
        tick();
        clr = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, expected finish", $time);
        $fatal(1);
    end

    initial begin
        // Rows: five back-to-back beats with the consumer always ready, then a drain cycle.
        vt[0] = '{1'b1, 1'b1, 32'd1, 1'b1, 5'd1, 1'b1, 32'd1, 32'd1, 32'd1};
        vt[1] = '{1'b1, 1'b1, 32'd2, 1'b1, 5'd1, 1'b1, 32'd2, 32'd2, 32'd2};
        vt[2] = '{1'b1, 1'b1, 32'd3, 1'b1, 5'd1, 1'b1, 32'd3, 32'd3, 32'd3};
        vt[3] = '{1'b1, 1'b1, 32'd4, 1'b1, 5'd1, 1'b1, 32'd4, 32'd4, 32'd4};
        vt[4] = '{1'b1, 1'b1, 32'd5, 1'b1, 5'd1, 1'b1, 32'd5, 32'd5, 32'd5};
        vt[5] = '{1'b0, 1'b1, 32'd0, 1'b1, 5'd0, 1'b0, 32'd0, 32'd5, 32'd5};

        #12;
        chk("rst_level", 64'(lvl), 64'd0);
        chk("rst_cvld",  64'(cvld), 64'd0);
        chk("rst_beat",  64'(beat), 64'd0);
        chk("rst_drop",  64'(drop), 64'd0);
        chk("rst_trig",  64'(trig), 64'd0);
        chk("rst_snoop", 64'(snoop), 64'd0);
        rst_n = 1'b1;
        tick();

        // Threshold 0 makes the trigger build start on the first beat, matching the plain build.
        en = 1'b1; arm = 1'b1; thr = 32'd0; decim = 16'd0;
        tick();
`ifdef SNOOP_TRIGGER_EN
        chk("trig_armed", 64'(trig), 64'd0);
`else
        chk("trig_run", 64'(trig), 64'd1);
`endif

        for (int i = 0; i < 6; i++) begin
            tvalid = vt[i].vld; tready = vt[i].rdy;
            tdata  = {vt[i].fld, 32'h0BAD_0000};
            crdy   = vt[i].crdy;
            tick();
            chk($sformatf("t1_lvl[%0d]", i),   64'(lvl),   64'(vt[i].lvl));
            chk($sformatf("t1_vld[%0d]", i),   64'(cvld),  64'(vt[i].cvld));
            chk($sformatf("t1_dat[%0d]", i),   64'(cdat),  64'(vt[i].cdat));
            chk($sformatf("t1_beat[%0d]", i),  64'(beat),  64'(vt[i].beat));
            chk($sformatf("t1_snoop[%0d]", i), 64'(snoop), 64'(vt[i].snoop));
        end
        crdy = 1'b0;
        chk("t1_drop", 64'(drop), 64'd0);

        do_clear();
        chk("clr_level", 64'(lvl), 64'd0);
        chk("clr_beat",  64'(beat), 64'd0);
        chk("clr_trig",  64'(trig), 64'd0);
        chk("clr_snoop", 64'(snoop), 64'd5);
        tick();

        // tvalid without tready is not a beat.
        tvalid = 1'b1; tready = 1'b0; tdata = {32'd77, 32'd0};
        for (int i = 0; i < 10; i++) tick();
        tvalid = 1'b0;
        chk("t2_beat", 64'(beat), 64'd0);
        chk("t2_cvld", 64'(cvld), 64'd0);

        decim = 16'd2;
        for (int i = 0; i < 9; i++) beat_in(32'(i));
        tvalid = 1'b0;
        chk("t3_level", 64'(lvl), 64'd3);
        chk("t3_beat",  64'(beat), 64'd9);
        chk("t3_snoop", 64'(snoop), 64'd6);
        pop_chk("t3_pop0", 32'd0);
        pop_chk("t3_pop1", 32'd3);
        pop_chk("t3_pop2", 32'd6);
        chk("t3_empty", 64'(lvl), 64'd0);

        do_clear();
        tick();
        decim = 16'd0;
        for (int i = 0; i < 18; i++) beat_in(32'(i));
        tvalid = 1'b0;
        chk("t4_level", 64'(lvl), 64'd16);
        chk("t4_drop",  64'(drop), 64'd2);
        chk("t4_snoop", 64'(snoop), 64'd17);
        chk("t4_head",  64'(cdat), 64'd0);
        crdy = 1'b1;
        beat_in(32'd99);
        crdy = 1'b0; tvalid = 1'b0;
        chk("t4_full_pp_level", 64'(lvl), 64'd16);
        chk("t4_full_pp_drop",  64'(drop), 64'd2);
        for (int i = 1; i < 16; i++) pop_chk($sformatf("t4_pop%0d", i), 32'(i));
        pop_chk("t4_pop_last", 32'd99);
        chk("t4_empty", 64'(lvl), 64'd0);

        do_clear();
        tick();
        for (int i = 0; i < 7; i++) beat_in(32'(100 + i));
        chk("t5_level7", 64'(lvl), 64'd7);
        #2 rst_n = 1'b0;
        #1;
        chk("t5_rst_level", 64'(lvl), 64'd0);
        chk("t5_rst_cvld",  64'(cvld), 64'd0);
        chk("t5_rst_cdat",  64'(cdat), 64'd0);
        chk("t5_rst_snoop", 64'(snoop), 64'd0);
        chk("t5_rst_beat",  64'(beat), 64'd0);
        chk("t5_rst_drop",  64'(drop), 64'd0);
        chk("t5_rst_trig",  64'(trig), 64'd0);
        tvalid = 1'b0;
        #2 rst_n = 1'b1;
        tick();
        tick();
        beat_in(32'd7); beat_in(32'd8); beat_in(32'd9);
        tvalid = 1'b0;
        chk("t5_pre_beat", 64'(beat), 64'd3);
        do_clear();
        chk("t5_clr_level", 64'(lvl), 64'd0);
        chk("t5_clr_beat",  64'(beat), 64'd0);
        chk("t5_clr_drop",  64'(drop), 64'd0);
        chk("t5_clr_snoop", 64'(snoop), 64'd9);

        en = 1'b0;
        tick();
        chk("dis_trig", 64'(trig), 64'd0);
        beat_in(32'd55);
        tvalid = 1'b0;
        chk("dis_beat",  64'(beat), 64'd0);
        chk("dis_level", 64'(lvl), 64'd0);

`ifdef SNOOP_TRIGGER_EN
        thr = 32'd100; arm = 1'b1; en = 1'b1;
        tick();
        chk("t6_armed_trig", 64'(trig), 64'd0);
        beat_in(32'd50);
        chk("t6_b50_trig", 64'(trig), 64'd0);
        beat_in(32'd99);
        chk("t6_b99_lvl", 64'(lvl), 64'd0);
        beat_in(32'd100);
        chk("t6_b100_trig", 64'(trig), 64'd1);
        beat_in(32'd20);
        tvalid = 1'b0;
        chk("t6_level", 64'(lvl), 64'd2);
        chk("t6_beat",  64'(beat), 64'd4);
        pop_chk("t6_pop0", 32'd100);
        pop_chk("t6_pop1", 32'd20);
`else
        arm = 1'b1; thr = 32'hFFFF_FFFF; en = 1'b1;
        tick();
        chk("noarm_trig", 64'(trig), 64'd1);
        beat_in(32'd50);
        tvalid = 1'b0;
        chk("noarm_level", 64'(lvl), 64'd1);
        chk("noarm_beat",  64'(beat), 64'd1);
        pop_chk("noarm_pop", 32'd50);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
